// File: rtl/maxnet_pkg.sv
// Shared definitions for the Maxnet iteration controller: neuron count, IEEE-754
// single-precision field positions and the controller state encoding.
package maxnet_pkg;

    localparam int N_NEURON  = 4;
    localparam int FP_SIGN   = 31;
    localparam int FP_EXP_HI = 30;
    localparam int FP_EXP_LO = 23;
    localparam int FP_MAN_HI = 22;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/fp_relu.sv
// Combinational floating-point ReLU: negative values and both signed zeros map to +0.
module fp_relu
    import maxnet_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] x,
    output logic [XLEN-1:0] y
);

    logic mag_zero;

    assign mag_zero = ({x[FP_EXP_HI:FP_EXP_LO], x[FP_MAN_HI:0]} == '0);
    assign y        = (x[FP_SIGN] || mag_zero) ? XLEN'(FP_ZERO) : x;

endmodule

// File: rtl/maxnet_iteration_controller.sv
// Maxnet feedback controller: applies ReLU to PU results, recirculates activations until at
// most one neuron survives. Optional macro MAXNET_TIMEOUT_EN enables the MAX_ITER ceiling.
module maxnet_iteration_controller
    import maxnet_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int PU_LAT   = 3,
    parameter int MAX_ITER = 255,
    parameter int CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N_NEURON*XLEN-1:0] in_vals,
    input  logic [N_NEURON*XLEN-1:0] pu_results,
    output logic [N_NEURON*XLEN-1:0] pu_nums,
    output logic                     busy,
    output logic                     done,
    output logic                     no_winner,
    output logic                     timeout,
    output logic [1:0]               winner_idx,
    output logic [XLEN-1:0]          winner_val,
    output logic [CNT_W-1:0]         iter_count
);

    localparam int WAIT_W = (PU_LAT > 1) ? $clog2(PU_LAT) : 1;

`ifdef MAXNET_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    state_t                     state, state_nxt;
    logic [N_NEURON*XLEN-1:0]   act_reg;
    logic [N_NEURON*XLEN-1:0]   relu_src;
    logic [N_NEURON*XLEN-1:0]   relu_out;
    logic [WAIT_W-1:0]          wait_cnt;
    logic [2:0]                 nz_cnt;
    logic [1:0]                 nz_idx;
    logic                       timeout_hit;
    logic                       run_end;

    // One ReLU bank serves both the initial load and every capture.
    assign relu_src = (state == LOAD) ? in_vals : pu_results;

    for (genvar g = 0; g < N_NEURON; g++) begin : g_relu
        fp_relu #(.XLEN(XLEN)) u_relu (
            .x(relu_src[g*XLEN +: XLEN]),
            .y(relu_out[g*XLEN +: XLEN])
        );
    end

    always_comb begin
        nz_cnt = '0;
        nz_idx = '0;
        for (int i = 0; i < N_NEURON; i++) begin
            if (act_reg[i*XLEN +: XLEN] != '0) begin
                nz_cnt = nz_cnt + 3'd1;
                nz_idx = i[1:0];
            end
        end
    end

    assign timeout_hit = TIMEOUT_EN && (iter_count == CNT_W'(MAX_ITER));
    assign run_end     = (nz_cnt <= 3'd1) || timeout_hit;

    assign pu_nums = act_reg;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = CHECK;
            CHECK:   state_nxt = run_end ? DONE : WAIT;
            WAIT:    if (wait_cnt == '0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = CHECK;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Results are registered on the CHECK->DONE edge so they are valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_reg    <= '0;
            iter_count <= '0;
            wait_cnt   <= '0;
            no_winner  <= 1'b0;
            timeout    <= 1'b0;
            winner_idx <= '0;
            winner_val <= '0;
        end else begin
            case (state)
                LOAD: begin
                    act_reg    <= relu_out;
                    iter_count <= '0;
                    no_winner  <= 1'b0;
                    timeout    <= 1'b0;
                    winner_idx <= '0;
                    winner_val <= '0;
                end
                CHECK: begin
                    if (nz_cnt <= 3'd1) begin
                        no_winner  <= (nz_cnt == 3'd0);
                        winner_idx <= (nz_cnt == 3'd1) ? nz_idx : 2'd0;
                        winner_val <= (nz_cnt == 3'd1) ? act_reg[nz_idx*XLEN +: XLEN] : '0;
                    end else if (timeout_hit) begin
                        timeout    <= 1'b1;
                        winner_idx <= '0;
                        winner_val <= '0;
                    end else begin
                        wait_cnt <= WAIT_W'(PU_LAT - 1);
                    end
                end
                WAIT: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
                end
                CAPTURE: begin
                    act_reg <= relu_out;
                    if (iter_count != '1) iter_count <= iter_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_iteration_controller.sv
// Directed bench for maxnet_iteration_controller with a behavioural 3-stage PU row
// (diagonal weight 1.0, off-diagonal -0.2) closing the feedback loop.
module tb_maxnet_iteration_controller;

    localparam int XLEN = 32;
    localparam int CNT_W = 8;
    localparam logic [127:0] S1_VALS = {32'h3F4CCCCD, 32'h3F19999A, 32'h3ECCCCCD, 32'h3E4CCCCD};
    localparam logic [127:0] S2_VALS = {32'hBF800000, 32'h3F800000, 32'h00000000, 32'h00000000};
    localparam logic [127:0] S3_VALS = {32'hBF800000, 32'h80000000, 32'hBF800000, 32'hBF800000};
    localparam logic [127:0] S4_VALS = {32'h00000000, 32'h00000000, 32'h3F000000, 32'h3F000000};

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [127:0]     in_vals = '0;
    logic [127:0]     pu_results;
    logic [127:0]     pu_nums;
    logic             busy, done, no_winner, timeout;
    logic [1:0]       winner_idx;
    logic [XLEN-1:0]  winner_val;
    logic [CNT_W-1:0] iter_count;

    int errors = 0;
    int checks = 0;

    maxnet_iteration_controller #(
        .XLEN(XLEN), .PU_LAT(3), .MAX_ITER(16), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_vals(in_vals), .pu_results(pu_results),
        .pu_nums(pu_nums), .busy(busy), .done(done), .no_winner(no_winner),
        .timeout(timeout), .winner_idx(winner_idx), .winner_val(winner_val),
        .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] b);
        logic [10:0] e;
        if (b[30:23] == 8'd0) return 0.0;
        e = 11'(int'(b[30:23]) + 896);
        return $bitstoreal({b[31], e, b[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (e <= 0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Behavioural PU row: mult, add, add register stages.
    logic [127:0] pu_s1 = '0, pu_s2 = '0, pu_s3 = '0;
    real acc;
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            acc = 0.0;
            for (int j = 0; j < 4; j++)
                acc = acc + f2r(pu_nums[j*32 +: 32]) * ((i == j) ? 1.0 : f2r(32'hBE4CCCCD));
            pu_s1[i*32 +: 32] <= r2f(acc);
        end
        pu_s2 <= pu_s1;
        pu_s3 <= pu_s2;
    end
    assign pu_results = pu_s3;

    task automatic start_pulse(input logic [127:0] v);
        @(negedge clk);
        in_vals = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cyc, output bit seen);
        cyc = 1;
        seen = done;
        while (!seen && cyc < max) begin
            @(negedge clk);
            cyc++;
            seen = done;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (pu_nums !== 128'd0) begin errors++; $display("FAIL reset_pu_nums: got %h want 0", pu_nums); end
        checks++; if ({no_winner, timeout, winner_idx} !== 4'd0) begin errors++; $display("FAIL reset_flags: got %b want 0", {no_winner, timeout, winner_idx}); end
        checks++; if (winner_val !== 32'd0) begin errors++; $display("FAIL reset_winner_val: got %h want 0", winner_val); end
        checks++; if (iter_count !== 8'd0) begin errors++; $display("FAIL reset_iter: got %0d want 0", iter_count); end
    endtask

    // 0.2/0.4/0.6/0.8 converges after 5 passes; neuron 3 survives at ~0.420864.
    task automatic test_single_winner;
        int cyc; bit seen;
        start_pulse(S1_VALS);
        wait_done(200, cyc, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL s1_done: no done within %0d cycles", cyc); end
        checks++; if (cyc !== 28) begin errors++; $display("FAIL s1_latency: got %0d want 28", cyc); end
        checks++; if (winner_idx !== 2'd3) begin errors++; $display("FAIL s1_idx: got %0d want 3", winner_idx); end
        checks++; if (iter_count !== 8'd5) begin errors++; $display("FAIL s1_iter: got %0d want 5", iter_count); end
        checks++; if (winner_val[31:16] !== 16'h3ED7) begin errors++; $display("FAIL s1_val: got %h want 3ED7xxxx", winner_val); end
        checks++; if ({no_winner, timeout} !== 2'b00) begin errors++; $display("FAIL s1_flags: got %b want 00", {no_winner, timeout}); end
        @(negedge clk);
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL s1_after: done,busy got %b want 00", {done, busy}); end
        checks++; if (winner_idx !== 2'd3) begin errors++; $display("FAIL s1_hold: got %0d want 3", winner_idx); end
    endtask

    task automatic test_immediate_winner;
        int cyc; bit seen;
        start_pulse(S2_VALS);
        wait_done(50, cyc, seen);
        checks++; if (seen !== 1'b1 || cyc !== 3) begin errors++; $display("FAIL s2_latency: seen=%b cyc=%0d want 3", seen, cyc); end
        checks++; if (iter_count !== 8'd0) begin errors++; $display("FAIL s2_iter: got %0d want 0", iter_count); end
        checks++; if (winner_idx !== 2'd2) begin errors++; $display("FAIL s2_idx: got %0d want 2", winner_idx); end
        checks++; if (winner_val !== 32'h3F800000) begin errors++; $display("FAIL s2_val: got %h want 3F800000", winner_val); end
        checks++; if (no_winner !== 1'b0) begin errors++; $display("FAIL s2_no_winner: got %b want 0", no_winner); end
        checks++; if (pu_nums !== {32'h0, 32'h3F800000, 64'h0}) begin errors++; $display("FAIL s2_relu: got %h", pu_nums); end
    endtask

    task automatic test_all_negative;
        int cyc; bit seen;
        start_pulse(S3_VALS);
        wait_done(50, cyc, seen);
        checks++; if (seen !== 1'b1 || cyc !== 3) begin errors++; $display("FAIL s3_latency: seen=%b cyc=%0d want 3", seen, cyc); end
        checks++; if (no_winner !== 1'b1) begin errors++; $display("FAIL s3_no_winner: got %b want 1", no_winner); end
        checks++; if (winner_idx !== 2'd0) begin errors++; $display("FAIL s3_idx: got %0d want 0", winner_idx); end
        checks++; if (winner_val !== 32'd0) begin errors++; $display("FAIL s3_val: got %h want 0", winner_val); end
        checks++; if (iter_count !== 8'd0) begin errors++; $display("FAIL s3_iter: got %0d want 0", iter_count); end
        checks++; if (pu_nums !== 128'd0) begin errors++; $display("FAIL s3_neg_zero: got %h want 0", pu_nums); end
    endtask

    // Equal 0.5/0.5 never resolves; only the iteration ceiling can end it.
    task automatic test_tie;
        int cyc; bit seen;
        start_pulse(S4_VALS);
`ifdef MAXNET_TIMEOUT_EN
        wait_done(300, cyc, seen);
        checks++; if (seen !== 1'b1 || cyc !== 83) begin errors++; $display("FAIL s4_latency: seen=%b cyc=%0d want 83", seen, cyc); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL s4_timeout: got %b want 1", timeout); end
        checks++; if (iter_count !== 8'd16) begin errors++; $display("FAIL s4_iter: got %0d want 16", iter_count); end
        checks++; if ({winner_val, winner_idx, no_winner} !== 35'd0) begin errors++; $display("FAIL s4_winner: val=%h idx=%0d nw=%b want 0", winner_val, winner_idx, no_winner); end
        @(negedge clk);
`else
        wait_done(100, cyc, seen);
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL s4_no_ceiling: done after %0d cycles", cyc); end
        checks++; if ({busy, timeout} !== 2'b10) begin errors++; $display("FAIL s4_state: busy,timeout got %b want 10", {busy, timeout}); end
        checks++; if (iter_count < 8'd17) begin errors++; $display("FAIL s4_iter: got %0d want >16", iter_count); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
    endtask

    task automatic test_reset_mid_run;
        int cyc; bit seen;
        bit done_seen;
        start_pulse(S1_VALS);
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        checks++; if (pu_nums !== 128'd0) begin errors++; $display("FAIL rst_mid_pu_nums: got %h want 0", pu_nums); end
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            done_seen = done_seen | done;
        end
        checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got pulse want none"); end
        start_pulse(S1_VALS);
        wait_done(200, cyc, seen);
        checks++; if (seen !== 1'b1 || cyc !== 28) begin errors++; $display("FAIL rst_mid_rerun: seen=%b cyc=%0d want 28", seen, cyc); end
        checks++; if (winner_idx !== 2'd3 || iter_count !== 8'd5) begin errors++; $display("FAIL rst_mid_result: idx=%0d iter=%0d want 3/5", winner_idx, iter_count); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int cyc;
        start_pulse(S1_VALS);
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 10) begin
                start = 1'b1;
                in_vals = S2_VALS;
            end else begin
                start = 1'b0;
            end
        end
        checks++; if (done !== 1'b1 || cyc !== 28) begin errors++; $display("FAIL b2b_latency: done=%b cyc=%0d want 28", done, cyc); end
        checks++; if (winner_idx !== 2'd3 || iter_count !== 8'd5) begin errors++; $display("FAIL b2b_result: idx=%0d iter=%0d want 3/5", winner_idx, iter_count); end
        checks++; if (winner_val[31:16] !== 16'h3ED7) begin errors++; $display("FAIL b2b_val: got %h want 3ED7xxxx", winner_val); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done: busy got %b want 0", busy); end
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL start_in_done_late: busy,done got %b want 00", {busy, done}); end
        checks++; if (winner_idx !== 2'd3) begin errors++; $display("FAIL start_in_done_hold: idx got %0d want 3", winner_idx); end
    endtask

    initial begin
        test_reset;
        test_single_winner;
        test_immediate_winner;
        test_all_negative;
        test_tie;
        test_reset_mid_run;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
